// File: rtl/clock_gen_pkg.sv
// Shared mode encoding and default rates for the clock enable generator.
// Defaults assume a 50 MHz system clock.
package clock_gen_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_VLF    = 2'b01,
        MODE_LF     = 2'b10,
        MODE_HF     = 2'b11
    } clock_mode_t;

    localparam int DEFAULT_DIV_VLF         = 16_666_667;
    localparam int DEFAULT_DIV_LF          = 500_000;
    localparam int DEFAULT_DIV_HF          = 16_667;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clock_enable_generator_if.sv
// Control and status bundle of the clock enable generator: mode request, run and
// manual key in, tick / display level / applied mode out.
interface clock_enable_generator_if;
    logic       key_manual_n;
    logic [1:0] sel;
    logic       run;
    logic       tick;
    logic       clock_out;
    logic [1:0] sel_active;

    modport master (
        output key_manual_n, sel, run,
        input  tick, clock_out, sel_active
    );

    modport slave (
        input  key_manual_n, sel, run,
        output tick, clock_out, sel_active
    );
endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stability counter for a bouncing active-low key.
// key_pressed pulses for one cycle on the edge where the debounced level falls.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic key_raw_n,
    output logic key_level,
    output logic key_pressed
);

    localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_reg;
    logic            level_reg, level_next;
    logic            pressed_reg, pressed_next;
    logic [DB_W-1:0] cnt_reg, cnt_next;

    // Any cycle where the synced level agrees with the accepted level restarts the count.
    always_comb begin
        cnt_next     = '0;
        level_next   = level_reg;
        pressed_next = 1'b0;
        if (sync_reg[1] != level_reg) begin
            if (cnt_reg == DB_LAST) begin
                level_next   = sync_reg[1];
                pressed_next = ~sync_reg[1];
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg    <= 2'b11;
            level_reg   <= 1'b1;
            pressed_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync_reg    <= {sync_reg[0], key_raw_n};
            level_reg   <= level_next;
            pressed_reg <= pressed_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign key_level   = level_reg;
    assign key_pressed = pressed_reg;

endmodule

// File: rtl/clock_enable_generator.sv
// Single-cycle CPU clock enable from manual key or one of three rates, with
// run/halt, glitch-free mode changes and a toggling display level.
module clock_enable_generator
    import clock_gen_pkg::*;
#(
    parameter int DIV_VLF         = DEFAULT_DIV_VLF,
    parameter int DIV_LF          = DEFAULT_DIV_LF,
    parameter int DIV_HF          = DEFAULT_DIV_HF,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock_in,
    input  logic reset_n,
    clock_enable_generator_if.slave ctrl
);

    localparam int              DIV_MAX  = max3(DIV_VLF, DIV_LF, DIV_HF);
    localparam int              CNT_W    = $clog2(DIV_MAX);
    localparam logic [CNT_W-1:0] LAST_VLF = CNT_W'(DIV_VLF - 1);
    localparam logic [CNT_W-1:0] LAST_LF  = CNT_W'(DIV_LF - 1);
    localparam logic [CNT_W-1:0] LAST_HF  = CNT_W'(DIV_HF - 1);

    clock_mode_t      mode_reg, mode_next, sel_req;
    logic [CNT_W-1:0] cnt_reg, cnt_next, div_last;
    logic             tick_reg, tick_next;
    logic             clock_out_reg, clock_out_next;
    logic             key_level, key_pressed;
    logic             rate_mode, rate_hit, manual_hit, switch_now;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .key_raw_n   (ctrl.key_manual_n),
        .key_level   (key_level),
        .key_pressed (key_pressed)
    );

    assign sel_req = clock_mode_t'(ctrl.sel);

    always_comb begin
        div_last = LAST_HF;
        case (mode_reg)
            MODE_VLF: div_last = LAST_VLF;
            MODE_LF:  div_last = LAST_LF;
            default:  div_last = LAST_HF;
        endcase
    end

    // A pending switch waits for the old mode's tick unless nothing is counting,
    // so no tick interval is shorter than either mode's period.
    always_comb begin
        rate_mode      = (mode_reg != MODE_MANUAL);
        rate_hit       = rate_mode && ctrl.run && (cnt_reg == div_last);
        manual_hit     = (mode_reg == MODE_MANUAL) && key_pressed && !key_level;
        tick_next      = rate_hit || manual_hit;
        switch_now     = (sel_req != mode_reg) && (rate_hit || !rate_mode || !ctrl.run);
        mode_next      = switch_now ? sel_req : mode_reg;
        clock_out_next = clock_out_reg ^ tick_next;
        cnt_next       = cnt_reg;
        if (switch_now || rate_hit) begin
            cnt_next = '0;
        end else if (rate_mode && ctrl.run) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            mode_reg      <= MODE_MANUAL;
            cnt_reg       <= '0;
            tick_reg      <= 1'b0;
            clock_out_reg <= 1'b0;
        end else begin
            mode_reg      <= mode_next;
            cnt_reg       <= cnt_next;
            tick_reg      <= tick_next;
            clock_out_reg <= clock_out_next;
        end
    end

    assign ctrl.tick       = tick_reg;
    assign ctrl.clock_out  = clock_out_reg;
    assign ctrl.sel_active = mode_reg;

endmodule
